// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg -- shared types and constants for the hazard controller.
//   state_e    : controller FSM states (RUN / STALL / FLUSH)
//   FWD_*      : operand source select encoding driven on fwd_a / fwd_b
//   sb_slot_t  : one shadow-scoreboard slot {valid, rd, rf_enable, load}
//   PC_REG     : R15, never forwarded and never stalled on
//   src_match  : does a source register hit a given slot
//   fwd_sel    : youngest-wins select from a per-slot match vector
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] PC_REG = 4'd15;

    localparam int         NUM_SLOTS = 3;
    localparam logic [1:0] SLOT_EX   = 2'd0;
    localparam logic [1:0] SLOT_MEM  = 2'd1;
    localparam logic [1:0] SLOT_WB   = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       rf_enable;
        logic       load;
    } sb_slot_t;

    function automatic logic src_match(input sb_slot_t s, input logic [3:0] src, input logic used);
        return used && s.valid && s.rf_enable && (s.rd == src) && (src != PC_REG);
    endfunction

    // Youngest producer holds the newest value, so EX beats MEM beats WB.
    function automatic logic [1:0] fwd_sel(input logic [NUM_SLOTS-1:0] m);
        if (m[SLOT_EX])  return FWD_EX;
        if (m[SLOT_MEM]) return FWD_MEM;
        if (m[SLOT_WB])  return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- three-slot shadow of the EX/MEM/WB destination info.
//   clk, R        : clock, synchronous active-high reset (clears all slots)
//   bubble_i      : load a bubble into EX instead of the ID instruction
//   id_slot_i     : ID instruction's {valid, rd, rf_enable, load}
//   rn_i/rm_i     : ID source registers, uses_rn_i/uses_rm_i qualify them
//   match_rn_o/_rm_o : per-slot match vectors, bit index = SLOT_EX/MEM/WB
//   ex_load_o     : the EX slot holds a load
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 R,
    input  logic                 bubble_i,
    input  sb_slot_t             id_slot_i,
    input  logic [3:0]           rn_i,
    input  logic [3:0]           rm_i,
    input  logic                 uses_rn_i,
    input  logic                 uses_rm_i,
    output logic [NUM_SLOTS-1:0] match_rn_o,
    output logic [NUM_SLOTS-1:0] match_rm_o,
    output logic                 ex_load_o
);

    sb_slot_t [NUM_SLOTS-1:0] slot_q, slot_d;

    always_comb begin
        slot_d           = slot_q;
        slot_d[SLOT_EX]  = bubble_i ? sb_slot_t'('0) : id_slot_i;
        slot_d[SLOT_MEM] = slot_q[SLOT_EX];
        slot_d[SLOT_WB]  = slot_q[SLOT_MEM];
    end

    always_ff @(posedge clk) begin
        if (R) slot_q <= '0;
        else   slot_q <= slot_d;
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_match
        assign match_rn_o[g] = src_match(slot_q[g], rn_i, uses_rn_i);
        assign match_rm_o[g] = src_match(slot_q[g], rm_i, uses_rm_i);
    end

    assign ex_load_o = slot_q[SLOT_EX].load;

    // The load flag is dead once the producer reaches WB.
    logic unused_wb_load;
    assign unused_wb_load = slot_q[SLOT_WB].load;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard detection, forwarding select and branch flush.
//   clk, R            : clock, synchronous active-high reset
//   id_*              : decoded ID-stage instruction (sources, dest, flags)
//   pc_le, ifid_le    : PC / IF_ID load enables (0 while stalling)
//   ifid_flush        : squashes IF_ID for one cycle after a taken branch
//   cu_mux_s          : 1 injects a control bubble into ID_EX
//   fwd_a, fwd_b      : operand source select (FWD_RF/EX/MEM/WB)
//   stall_count       : saturating count of bubble cycles
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding;
// then only load-use stalls. Without it every in-flight producer stalls
// the consumer until it has left WB and fwd_a/fwd_b stay FWD_RF.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       R,
    input  logic       id_valid,
    input  logic [3:0] id_rn,
    input  logic [3:0] id_rm,
    input  logic       id_uses_rn,
    input  logic       id_uses_rm,
    input  logic [3:0] id_rd,
    input  logic       id_rf_enable,
    input  logic       id_load_instr,
    input  logic       id_branch_taken,
    output logic       pc_le,
    output logic       ifid_le,
    output logic       ifid_flush,
    output logic       cu_mux_s,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [7:0] stall_count
);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    sb_slot_t             id_slot;
    logic [NUM_SLOTS-1:0] match_rn, match_rm;
    logic                 ex_load, load_use, hazard;
    logic [1:0]           fwd_a_sel, fwd_b_sel;

    always_comb begin
        id_slot           = '0;
        id_slot.valid     = id_valid;
        id_slot.rd        = id_rd;
        id_slot.rf_enable = id_rf_enable;
        id_slot.load      = id_load_instr;
    end

    hazard_scoreboard u_sb (
        .clk        (clk),
        .R          (R),
        .bubble_i   (cu_mux_s),
        .id_slot_i  (id_slot),
        .rn_i       (id_rn),
        .rm_i       (id_rm),
        .uses_rn_i  (id_uses_rn),
        .uses_rm_i  (id_uses_rm),
        .match_rn_o (match_rn),
        .match_rm_o (match_rm),
        .ex_load_o  (ex_load)
    );

    assign load_use = id_valid & ex_load & (match_rn[SLOT_EX] | match_rm[SLOT_EX]);

`ifdef HAZARD_FORWARDING_EN
    assign hazard    = load_use;
    assign fwd_a_sel = fwd_sel(match_rn);
    assign fwd_b_sel = fwd_sel(match_rm);
`else
    // Load-use is a subset of "any producer in flight"; kept explicit so
    // both builds share the same detection terms.
    assign hazard    = load_use | (id_valid & (|match_rn | |match_rm));
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    // STALL re-evaluates exactly like RUN; a hazard always masks the branch,
    // so a branch held in ID during a stall is acted on once it releases.
    always_comb begin
        state_d    = state_q;
        pc_le      = 1'b1;
        ifid_le    = 1'b1;
        ifid_flush = 1'b0;
        cu_mux_s   = 1'b0;
        fwd_a      = fwd_a_sel;
        fwd_b      = fwd_b_sel;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (hazard) begin
                    pc_le    = 1'b0;
                    ifid_le  = 1'b0;
                    cu_mux_s = 1'b1;
                    state_d  = ST_STALL;
                end else if (id_branch_taken) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                ifid_flush = 1'b1;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        // Reset overrides combinationally so stale scoreboard contents
        // never leak out while R is held.
        if (R) begin
            state_d    = ST_RUN;
            pc_le      = 1'b1;
            ifid_le    = 1'b1;
            ifid_flush = 1'b0;
            cu_mux_s   = 1'b0;
            fwd_a      = FWD_RF;
            fwd_b      = FWD_RF;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cu_mux_s && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = R ? 8'd0 : cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- table-driven directed bench for hazard_ctrl, plus
// hand-written sequences for stall release timing and counter saturation.
// Expectations follow the HAZARD_FORWARDING_EN setting of the build.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [3:0] rn, rm;
        logic       urn, urm;
        logic [3:0] rd;
        logic       rfe, ld, br;
    } ins_t;

    typedef struct packed {
        logic       pc, ifl, fl, cu;
        logic [1:0] fa, fb;
        logic [7:0] cnt;
    } exp_t;

    typedef struct packed {
        logic r;
        ins_t i;
        exp_t e;
    } vec_t;

    localparam ins_t NOP = '0;

    logic clk = 1'b0;
    logic R;
    logic id_valid, id_uses_rn, id_uses_rm, id_rf_enable, id_load_instr, id_branch_taken;
    logic [3:0] id_rn, id_rm, id_rd;
    logic pc_le, ifid_le, ifid_flush, cu_mux_s;
    logic [1:0] fwd_a, fwd_b;
    logic [7:0] stall_count;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    hazard_ctrl dut (
        .clk(clk), .R(R),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_rd(id_rd), .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
        .id_branch_taken(id_branch_taken),
        .pc_le(pc_le), .ifid_le(ifid_le), .ifid_flush(ifid_flush), .cu_mux_s(cu_mux_s),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach summary");
        $fatal(1, "watchdog");
    end

    function automatic ins_t op(input logic [3:0] rd, input logic rfe, input logic ld,
                                input logic [3:0] rn, input logic urn,
                                input logic [3:0] rm, input logic urm, input logic br);
        ins_t t;
        t.v = 1'b1; t.rd = rd; t.rfe = rfe; t.ld = ld;
        t.rn = rn; t.urn = urn; t.rm = rm; t.urm = urm; t.br = br;
        return t;
    endfunction

    function automatic exp_t mk_e(input logic pc, input logic ifl, input logic fl, input logic cu,
                                  input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] c);
        exp_t e;
        e.pc = pc; e.ifl = ifl; e.fl = fl; e.cu = cu; e.fa = fa; e.fb = fb; e.cnt = c;
        return e;
    endfunction

    function automatic exp_t run_e(input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] c);
        return mk_e(1'b1, 1'b1, 1'b0, 1'b0, fa, fb, c);
    endfunction

    function automatic exp_t stall_e(input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] c);
        return mk_e(1'b0, 1'b0, 1'b0, 1'b1, fa, fb, c);
    endfunction

    function automatic exp_t flush_e(input logic [7:0] c);
        return mk_e(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, c);
    endfunction

    task automatic push(input logic r, input ins_t i, input exp_t e);
        vec_t t;
        t.r = r; t.i = i; t.e = e;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic r, input ins_t i);
        R = r;
        id_valid = i.v; id_rn = i.rn; id_rm = i.rm;
        id_uses_rn = i.urn; id_uses_rm = i.urm;
        id_rd = i.rd; id_rf_enable = i.rfe; id_load_instr = i.ld;
        id_branch_taken = i.br;
    endtask

    task automatic check_row(input string name, input int idx, input exp_t e);
        exp_t act;
        act = mk_e(pc_le, ifid_le, ifid_flush, cu_mux_s, fwd_a, fwd_b, stall_count);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s[%0d] got pc=%b if=%b fl=%b cu=%b fa=%b fb=%b cnt=%0d want pc=%b if=%b fl=%b cu=%b fa=%b fb=%b cnt=%0d",
                     name, idx, act.pc, act.ifl, act.fl, act.cu, act.fa, act.fb, act.cnt,
                     e.pc, e.ifl, e.fl, e.cu, e.fa, e.fb, e.cnt);
        end
    endtask

    task automatic build_table();
        exp_t E0;
        ins_t t, s, b, c;
        E0 = run_e(2'b00, 2'b00, 8'd0);
        // reset state, then taken branch -> one flush cycle
        push(1, NOP, E0);
        push(1, NOP, E0);
        push(0, NOP, E0);
        push(0, op(0, 0, 0, 0, 0, 0, 0, 1), E0);
        push(0, NOP, flush_e(8'd0));
        push(0, NOP, E0);
        // R15 is never a hazard or a forward
        push(0, op(15, 1, 0, 0, 0, 0, 0, 0), E0);
        push(0, op(2, 1, 0, 15, 1, 15, 1, 0), E0);
        push(0, NOP, E0);
        push(0, NOP, E0);
        push(0, NOP, E0);
        // producer without rf_enable
        push(0, op(3, 0, 0, 0, 0, 0, 0, 0), E0);
        push(0, op(0, 0, 0, 3, 1, 0, 0, 0), E0);
        // invalid producer
        t = op(6, 1, 0, 0, 0, 0, 0, 0);
        t.v = 1'b0;
        push(0, t, E0);
        push(0, op(0, 0, 0, 6, 1, 0, 0, 0), E0);
        // unused sources
        push(0, op(3, 1, 0, 0, 0, 0, 0, 0), E0);
        push(0, op(0, 0, 0, 3, 0, 3, 0, 0), E0);
        push(1, NOP, E0);
        push(0, NOP, E0);
`ifdef HAZARD_FORWARDING_EN
        push(0, op(1, 1, 0, 7, 1, 8, 1, 0), E0);                  // ADD r1
        push(0, op(2, 1, 0, 1, 1, 3, 1, 0), run_e(2'b01, 2'b00, 8'd0)); // SUB r2,r1,r3
        push(0, op(0, 0, 0, 2, 1, 1, 1, 0), run_e(2'b01, 2'b10, 8'd0));
        push(0, op(0, 0, 0, 1, 1, 9, 0, 0), run_e(2'b11, 2'b00, 8'd0));
        push(0, op(5, 1, 0, 0, 0, 0, 0, 0), E0);
        push(0, op(5, 1, 0, 0, 0, 0, 0, 0), E0);
        push(0, op(0, 0, 0, 5, 1, 5, 1, 0), run_e(2'b01, 2'b01, 8'd0)); // EX over MEM
        push(0, op(0, 0, 0, 5, 1, 0, 0, 0), run_e(2'b10, 2'b00, 8'd0)); // MEM over WB
        push(0, NOP, E0);
        // load-use: one bubble, then MEM forward on both operands
        push(0, op(4, 1, 1, 10, 1, 0, 0, 0), E0);
        s = op(5, 1, 0, 4, 1, 4, 1, 0);
        push(0, s, stall_e(2'b01, 2'b01, 8'd0));
        push(0, s, run_e(2'b10, 2'b10, 8'd1));
        push(0, NOP, run_e(2'b00, 2'b00, 8'd1));
        // stall beats branch
        push(0, op(6, 1, 1, 0, 0, 0, 0, 0), run_e(2'b00, 2'b00, 8'd1));
        b = op(0, 0, 0, 6, 1, 0, 0, 1);
        push(0, b, stall_e(2'b01, 2'b00, 8'd1));
        push(0, b, run_e(2'b10, 2'b00, 8'd2));
        push(0, NOP, flush_e(8'd2));
        push(0, NOP, run_e(2'b00, 2'b00, 8'd2));
        // mid-stall reset
        push(0, op(4, 1, 1, 0, 0, 0, 0, 0), run_e(2'b00, 2'b00, 8'd2));
        c = op(0, 0, 0, 4, 1, 0, 0, 0);
        push(0, c, stall_e(2'b01, 2'b00, 8'd2));
`else
        push(0, op(1, 1, 0, 7, 1, 8, 1, 0), E0);                  // ADD r1
        s = op(2, 1, 0, 1, 1, 3, 1, 0);                           // SUB r2,r1,r3
        push(0, s, stall_e(2'b00, 2'b00, 8'd0));
        push(0, s, stall_e(2'b00, 2'b00, 8'd1));
        push(0, s, stall_e(2'b00, 2'b00, 8'd2));
        push(0, s, run_e(2'b00, 2'b00, 8'd3));
        push(0, NOP, run_e(2'b00, 2'b00, 8'd3));
        // load-use also waits the full three cycles
        push(0, op(4, 1, 1, 10, 1, 0, 0, 0), run_e(2'b00, 2'b00, 8'd3));
        s = op(5, 1, 0, 4, 1, 4, 1, 0);
        push(0, s, stall_e(2'b00, 2'b00, 8'd3));
        push(0, s, stall_e(2'b00, 2'b00, 8'd4));
        push(0, s, stall_e(2'b00, 2'b00, 8'd5));
        push(0, s, run_e(2'b00, 2'b00, 8'd6));
        push(0, NOP, run_e(2'b00, 2'b00, 8'd6));
        // stall beats branch
        push(0, op(6, 1, 0, 0, 0, 0, 0, 0), run_e(2'b00, 2'b00, 8'd6));
        b = op(0, 0, 0, 6, 1, 0, 0, 1);
        push(0, b, stall_e(2'b00, 2'b00, 8'd6));
        push(0, b, stall_e(2'b00, 2'b00, 8'd7));
        push(0, b, stall_e(2'b00, 2'b00, 8'd8));
        push(0, b, run_e(2'b00, 2'b00, 8'd9));
        push(0, NOP, flush_e(8'd9));
        push(0, NOP, run_e(2'b00, 2'b00, 8'd9));
        // mid-stall reset
        push(0, op(4, 1, 0, 0, 0, 0, 0, 0), run_e(2'b00, 2'b00, 8'd9));
        c = op(0, 0, 0, 4, 1, 0, 0, 0);
        push(0, c, stall_e(2'b00, 2'b00, 8'd9));
`endif
        push(1, c, E0);
        push(0, c, E0);                                           // empty scoreboard, no stale forward
        // mid-flush reset
        push(0, op(0, 0, 0, 0, 0, 0, 0, 1), E0);
        push(1, NOP, E0);
        push(0, NOP, E0);
    endtask

    initial begin
        int n;
        drive(1'b1, NOP);
        build_table();

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].r, tbl[k].i);
            #2;
            check_row("vec", k, tbl[k].e);
        end

        // stall length bound: a load producer followed by its consumer
        @(negedge clk); drive(1'b1, NOP);
        @(negedge clk); drive(1'b0, NOP);
        @(negedge clk); drive(1'b0, op(9, 1, 1, 0, 0, 0, 0, 0));
        @(negedge clk); drive(1'b0, op(0, 0, 0, 9, 1, 0, 0, 0));
        #2;
        n = 0;
        while (!pc_le && n < 8) begin
            n++;
            @(negedge clk);
            #2;
        end
        checks++;
        if (n != (FWD ? 1 : 3)) begin
            errors++;
            $display("FAIL stall_len got %0d cycles want %0d", n, (FWD ? 1 : 3));
        end

        // counter saturation: a self-dependent load held in ID stalls repeatedly
        @(negedge clk); drive(1'b1, NOP);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            drive(1'b0, op(1, 1, 1, 1, 1, 0, 0, 0));
        end
        #2;
        checks++;
        if (stall_count !== 8'd255) begin
            errors++;
            $display("FAIL sat got %0d want 255", stall_count);
        end
        for (int k = 0; k < 50; k++) @(negedge clk);
        #2;
        checks++;
        if (stall_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold got %0d want 255", stall_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
